ex_mem_stage: RTL

- Execute stage of the 5-stage MIPS pipeline, plus the EX/MEM pipeline latch.
- Consumes the ID/EX latch outputs and computes ALU control, the ALU result, the zero flag, the branch target and the destination register.
- Registers all of these into the EX/MEM latch, whose outputs drive the memory stage directly (wb_ctlout, branch, memread, memwrite, zero, alu_result, rdata2out, five_bit_muxout).
- Supports a stall (hold) and a flush (bubble insert) from hazard logic.

---
 rtl/ex_mem_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - MIPS execute stage with EX/MEM pipeline latch
// ALU control decode, ALU, branch target and destination select, registered for MEM.
module ex_mem_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic [1:0]    wb_ctl,
  input  logic [2:0]    m_ctl,
  input  logic [3:0]    ex_ctl,
  input  logic [DW-1:0] npc,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  input  logic [DW-1:0] s_extendout,
  input  logic [AW-1:0] instr_2016,
  input  logic [AW-1:0] instr_1511,
  output logic [1:0]    wb_ctlout,
  output logic          branch,
  output logic          memread,
  output logic          memwrite,
  output logic [DW-1:0] add_result,
  output logic          zero,
  output logic [DW-1:0] alu_result,
  output logic [DW-1:0] rdata2out,
  output logic [AW-1:0] five_bit_muxout
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  logic          regdst;
  logic [1:0]    aluop;
  logic          alusrc;
  logic [5:0]    funct;
  logic [3:0]    alu_ctl;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_out;
  logic [DW-1:0] target;
  logic [AW-1:0] dest;

  assign regdst = ex_ctl[3];
  assign aluop  = ex_ctl[2:1];
  assign alusrc = ex_ctl[0];
  assign funct  = s_extendout[5:0];

  assign alu_b  = alusrc ? s_extendout : rdata2;
  assign dest   = regdst ? instr_1511 : instr_2016;
  assign target = npc + (s_extendout << 2);

  always_comb begin
    alu_ctl = ALU_BAD;
    case (aluop)
      2'b00: alu_ctl = ALU_ADD;
      2'b01: alu_ctl = ALU_SUB;
      2'b10: begin
        case (funct)
          6'b100000: alu_ctl = ALU_ADD;
          6'b100010: alu_ctl = ALU_SUB;
          6'b100100: alu_ctl = ALU_AND;
          6'b100101: alu_ctl = ALU_OR;
          6'b101010: alu_ctl = ALU_SLT;
          default:   alu_ctl = ALU_BAD;
        endcase
      end
      default: alu_ctl = ALU_BAD;
    endcase
  end

  // Unrecognised selects produce zero, which also raises the zero flag.
  always_comb begin
    alu_out = '0;
    case (alu_ctl)
      ALU_ADD: alu_out = rdata1 + alu_b;
      ALU_SUB: alu_out = rdata1 - alu_b;
      ALU_AND: alu_out = rdata1 & alu_b;
      ALU_OR:  alu_out = rdata1 | alu_b;
      ALU_SLT: alu_out = ($signed(rdata1) < $signed(alu_b)) ? {{(DW-1){1'b0}}, 1'b1} : '0;
      default: alu_out = '0;
    endcase
  end

  // Flush beats stall so a bubble can be inserted while the front end is held.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wb_ctlout       <= '0;
      branch          <= 1'b0;
      memread         <= 1'b0;
      memwrite        <= 1'b0;
      add_result      <= '0;
      zero            <= 1'b0;
      alu_result      <= '0;
      rdata2out       <= '0;
      five_bit_muxout <= '0;
    end else if (!stall) begin
      wb_ctlout       <= wb_ctl;
      branch          <= m_ctl[2];
      memread         <= m_ctl[1];
      memwrite        <= m_ctl[0];
      add_result      <= target;
      zero            <= (alu_out == '0);
      alu_result      <= alu_out;
      rdata2out       <= rdata2;
      five_bit_muxout <= dest;
    end
  end

endmodule
